// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, instruction field positions and
// the fetch state encoding. Imported by the fetch unit and the decode stage.
package cpu_pkg;

  localparam int IW  = 19;  // instruction width, fixed by the ISA
  localparam int PCW = 5;   // program counter counts instructions
  localparam int AW  = 8;   // program-memory byte address width

  // Opcodes, instruction bits [18:15]
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_CMP    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_INC    = 4'b0011;
  localparam logic [3:0] OP_MOV    = 4'b0100;
  localparam logic [3:0] OP_MVI_LD = 4'b0101;
  localparam logic [3:0] OP_MVI_ST = 4'b0110;
  localparam logic [3:0] OP_LD     = 4'b0111;
  localparam logic [3:0] OP_JZ     = 4'b1000;
  localparam logic [3:0] OP_JNZ    = 4'b1001;

  // Instruction field slice positions
  localparam int OPC_MSB   = 18;
  localparam int OPC_LSB   = 15;
  localparam int FLD_A_MSB = 14;
  localparam int FLD_A_LSB = 10;
  localparam int FLD_B_MSB = 9;
  localparam int FLD_B_LSB = 5;
  localparam int FLD_C_MSB = 4;
  localparam int FLD_C_LSB = 0;

  // Fetch FSM: F0..F2 request instruction bytes 0..2, HOLD presents pline
  typedef enum logic [1:0] {
    F0   = 2'd0,
    F1   = 2'd1,
    F2   = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads each 19-bit instruction as three
// little-endian bytes over the 8-bit program-memory bus and presents it to the
// decode stage. A taken jump (redirect) drops in-flight work and restarts the
// fetch at the target instruction.
//
// Handshakes:
//   memory : mem_rd is held with a stable mem_addr until mem_ack; mem_data is
//            sampled only in the mem_ack cycle. Dropping mem_rd (or moving the
//            address on a redirect) cancels the outstanding read.
//   decode : pline_valid stays high and pline stays stable until a cycle with
//            pline_ready=1; that cycle completes the transfer. pline_valid
//            never depends on pline_ready combinationally.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int IW       = 19,
  parameter int AW       = 8,
  parameter int PCW      = 5,
  parameter int RESET_PC = 0
) (
  input  logic           clk,
  input  logic           rst,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  input  logic [7:0]     mem_data,
  input  logic           mem_ack,
  output logic [IW-1:0]  pline,
  output logic           pline_valid,
  input  logic           pline_ready,
  input  logic           redirect,
  input  logic [PCW-1:0] redirect_pc,
  output logic [PCW-1:0] pc
);

  fetch_state_t  state;
  logic [7:0]    byte0;
  logic [7:0]    byte1;
  logic [AW-1:0] base;
  logic          unused_hi;

  // Byte address of instruction p: p*3 as a shift-and-add, never overflows AW.
  function automatic logic [AW-1:0] base_of(input logic [PCW-1:0] p);
    return AW'({p, 1'b0}) + AW'(p);
  endfunction

  // Base address of the instruction currently being fetched.
  assign base = base_of(pc);

  // Upper bits of the third byte carry no instruction bits.
  assign unused_hi = ^mem_data[7:3];

  // Fetch FSM; all outputs are registered here. Reset beats redirect, and
  // redirect beats every state transition (including a coincident mem_ack).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= F0;
      pc          <= PCW'(RESET_PC);
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      pline       <= '0;
      pline_valid <= 1'b0;
      byte0       <= '0;
      byte1       <= '0;
    end else if (redirect) begin
      state       <= F0;
      pc          <= redirect_pc;
      mem_rd      <= 1'b1;
      mem_addr    <= base_of(redirect_pc);
      pline_valid <= 1'b0;
    end else begin
      case (state)
        F0: begin
          // Straight out of reset no request is outstanding yet: issue it.
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= base;
          end else if (mem_ack) begin
            byte0    <= mem_data;
            mem_addr <= base + AW'(1);
            state    <= F1;
          end
        end
        F1: begin
          if (mem_ack) begin
            byte1    <= mem_data;
            mem_addr <= base + AW'(2);
            state    <= F2;
          end
        end
        F2: begin
          if (mem_ack) begin
            pline       <= IW'({mem_data[2:0], byte1, byte0});
            pline_valid <= 1'b1;
            mem_rd      <= 1'b0;
            pc          <= pc + PCW'(1);
            state       <= HOLD;
          end
        end
        HOLD: begin
          // No prefetch: the next request starts once decode takes pline.
          if (pline_ready) begin
            pline_valid <= 1'b0;
            mem_rd      <= 1'b1;
            mem_addr    <= base;
            state       <= F0;
          end
        end
        default: state <= F0;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit that supplies the 19-bit instruction word `pline` to the decode/control/execute stage. It owns the program counter and reads each instruction as three bytes over the 8-bit program-memory bus. It assembles each instruction and presents it through a valid/ready handshake. On a jump redirect from the decode stage it discards in-flight work and restarts fetch at the jump target.

## Interface
Parameters:
- `IW`, 19: instruction width; fixed by the ISA, only 19 is legal.
- `AW`, 8: program-memory byte address width.
- `PCW`, 5: program-counter width; PC counts instructions, not bytes.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mem_addr`  out  AW: byte address of current memory read.
- `mem_rd`  out  1: read request; held with stable `mem_addr` until `mem_ack`.
- `mem_data`  in  8: read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1: read completion; may be asserted the same cycle as `mem_rd`.
- `pline`  out  IW: instruction to decode stage.
- `pline_valid`  out  1: `pline` holds an unconsumed instruction.
- `pline_ready`  in  1: decode stage accepts `pline` this cycle.
- `redirect`  in  1: taken jump (opcode 1000/1001 resolved by decode).
- `redirect_pc`  in  PCW: jump target, the `<topc>` field.
- `pc`  out  PCW: index of the instruction currently being fetched or held.

## Operation
- Byte address of an instruction: `base = pc*3`, computed in AW bits. The maximum is 31*3+2 = 95, so it never overflows.
- Byte order is little-endian:
  - byte at `base+0` goes to `pline[7:0]`.
  - byte at `base+1` goes to `pline[15:8]`.
  - `mem_data[2:0]` of the byte at `base+2` goes to `pline[18:16]`; bits [7:3] of that byte are ignored.
- FSM states:
  - `F0`, `F1`, `F2`: request byte 0, 1 or 2. `mem_rd`=1 and `mem_addr`=`base+n`.
  - `HOLD`: `mem_rd`=0 and `pline_valid`=1.
- Transitions:
  - `Fn` advances to the next state only on `mem_ack`, capturing `mem_data` into its assembly slice.
  - `F2` with `mem_ack`: the full word goes to `pline`, `pline_valid` goes to 1 next cycle, the state moves to `HOLD`, and `pc` increments (mod 32, so 31 wraps to 0).
  - `HOLD` with `pline_ready`: `pline_valid` goes to 0 and the state moves to `F0`.
- No prefetch. A new fetch starts only after the held instruction is consumed.
- Redirect has priority in every state:
  - Next cycle: `pc` is `redirect_pc`, state is `F0`, `pline_valid` is 0.
  - Any partial assembly is discarded.
- Memory protocol: deasserting `mem_rd` before `mem_ack` cancels the read. An `mem_ack` arriving in the same cycle as `redirect` is ignored.
- If `redirect` and `pline_ready` are asserted with `pline_valid`=1, the transfer counts as completed and the redirect is still applied.
- `pline` is unchanged from the capture cycle until the next capture. It is never modified while `pline_valid`=1.

## Timing
- Reset values:
  - `pc` is RESET_PC and `mem_addr` is 0.
  - `mem_rd`, `pline` and `pline_valid` are 0.
  - State is `F0`, so `mem_rd` rises in the first cycle after `rst` drops, with `mem_addr`=RESET_PC*3.
- An `rst` pulse mid-fetch or in `HOLD` forces the reset values on the next edge. It overrides `redirect`.
- With zero-wait memory (`mem_ack` tied to `mem_rd`):
  - 3 request cycles, then `pline_valid` is high in cycle 4.
  - With `pline_ready`=1 constantly, one instruction is delivered every 4 cycles.
- Each memory wait cycle adds one cycle of latency.
- Redirect to first byte request of the target: 1 cycle.
- Outputs are registered. The only combinational paths are from `mem_ack` into next-state logic and from `pline_ready`/`redirect` into next-state logic; no input reaches an output combinationally.

## Structure
- Shared package `cpu_pkg`:
  - `IW`, `PCW`, `AW`.
  - Opcode constants: ADD=0000, CMP=0001, SUB=0010, INC=0011, MOV=0100, MVI_LD=0101, MVI_ST=0110, LD=0111, JZ=1000, JNZ=1001.
  - Field slice positions: opcode [18:15], fields [14:10], [9:5], [4:0].
  - Fetch state enum.
- Decode stage and this unit both import `cpu_pkg`.
- Single module, no sub-modules. The address multiply is `{pc,1'b0}+pc`, not a generic multiplier.

## Test plan
- Reset then zero-wait memory holding 0x01,0x02,0x05 at addresses 0..2:
  - `mem_addr` sequence 0,1,2.
  - `pline`=19'h50201 valid in cycle 4.
  - `pc`=1.
- `pline_ready` low for 5 cycles: `pline_valid` stays 1, `pline` stays stable and `mem_rd` stays 0; fetch at address 3 starts the cycle after `ready` rises.
- Memory with 2 wait cycles per byte: `pline_valid` rises 10 cycles after the first `mem_rd`, and `mem_addr` is held through the waits.
- `redirect`=1 with `redirect_pc`=7 during `F1`:
  - partial bytes are discarded.
  - next cycle `mem_addr`=21 and `pc`=7.
  - an `mem_ack` coincident with the redirect has no effect.
- Start at `pc`=31: address 93..95 is fetched and `pc` wraps to 0. `rst` asserted during `HOLD` clears `pline_valid`, then `mem_addr`=0 after release.
